// File: rtl/keccak_pkg.sv
// Shared types and constants for the slice-serial Keccak round controller.
package keccak_pkg;

    localparam int unsigned KECCAK_SLICES = 64;
    localparam int unsigned KECCAK_ROUNDS = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_START = 3'd2,
        ST_CALC  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int unsigned cw(input int unsigned n);
        return ($clog2(n) > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with sync clear, parallel load and terminal-count flag.
module mod_counter
    import keccak_pkg::*;
#(
    parameter int unsigned MOD = 2,
    parameter int unsigned W   = cw(MOD)
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_ld,
    input  logic [W-1:0] i_ld_val,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] r_cnt;

    // Clear wins over load, load wins over count.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_ld_val;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/keccak_round_ctrl.sv
// Moore controller sequencing one round or a full permutation over SLICES slices per round.
module keccak_round_ctrl
    import keccak_pkg::*;
#(
    parameter int unsigned SLICES = KECCAK_SLICES,
    parameter int unsigned ROUNDS = KECCAK_ROUNDS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic [cw(ROUNDS)-1:0]     round_in,
    output logic                      ready,
    output logic                      clr_reg,
    output logic                      put_input,
    output logic                      ld_reg,
    output logic                      feedback,
    output logic [cw(SLICES)-1:0]     slice_idx,
    output logic [cw(ROUNDS)-1:0]     round_idx,
    output logic                      round_done,
    output logic                      done
);

    localparam int unsigned    SW         = cw(SLICES);
    localparam int unsigned    RW         = cw(ROUNDS);
    localparam logic [RW-1:0]  LAST_ROUND = RW'(ROUNDS - 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_mode;
    logic            w_accept;
    logic [RW-1:0]   w_round_load;
    logic [SW-1:0]   w_slice;
    logic [RW-1:0]   w_round;
    logic            w_slice_tc;
    logic            w_round_tc;

    assign w_accept = (r_state == ST_IDLE) && start;

    always_comb begin
        w_round_load = '0;
        if (!mode) begin
            w_round_load = (round_in > LAST_ROUND) ? LAST_ROUND : round_in;
        end
    end

    mod_counter #(
        .MOD (SLICES),
        .W   (SW)
    ) u_slice_cnt (
        .i_clk    (clk),
        .i_clr    (rst || (r_state == ST_INIT)),
        .i_en     (r_state == ST_CALC),
        .i_ld     (1'b0),
        .i_ld_val ('0),
        .o_cnt    (w_slice),
        .o_tc     (w_slice_tc)
    );

    // Advancing on the NEXT cycle keeps round_idx fixed across each CALC phase.
    mod_counter #(
        .MOD (ROUNDS),
        .W   (RW)
    ) u_round_cnt (
        .i_clk    (clk),
        .i_clr    (rst),
        .i_en     (r_state == ST_NEXT),
        .i_ld     (w_accept),
        .i_ld_val (w_round_load),
        .o_cnt    (w_round),
        .o_tc     (w_round_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mode <= mode;
            end
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_next = start ? ST_INIT : ST_IDLE;
            ST_INIT:  w_next = ST_START;
            ST_START: w_next = ST_CALC;
            ST_CALC: begin
                w_next = ST_CALC;
                if (w_slice_tc) begin
                    w_next = (!r_mode || w_round_tc) ? ST_DONE : ST_NEXT;
                end
            end
            ST_NEXT:  w_next = ST_CALC;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign ready      = (r_state == ST_IDLE);
    assign clr_reg    = (r_state == ST_INIT);
    assign put_input  = (r_state == ST_START);
    assign ld_reg     = (r_state == ST_CALC);
    assign feedback   = (r_state == ST_CALC) && r_mode && (w_round != '0);
    assign round_done = (r_state == ST_CALC) && w_slice_tc;
    assign done       = (r_state == ST_DONE);
    assign slice_idx  = w_slice;
    assign round_idx  = w_round;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Directed bench: default-size instance (A) and a SLICES=4/ROUNDS=3 instance (B).
module tb_keccak_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic       a_start = 1'b0, a_mode = 1'b0;
    logic [4:0] a_round_in = '0;
    logic       a_ready, a_clr_reg, a_put_input, a_ld_reg, a_feedback, a_round_done, a_done;
    logic [5:0] a_slice_idx;
    logic [4:0] a_round_idx;

    logic       b_start = 1'b0, b_mode = 1'b0;
    logic [1:0] b_round_in = '0;
    logic       b_ready, b_clr_reg, b_put_input, b_ld_reg, b_feedback, b_round_done, b_done;
    logic [1:0] b_slice_idx;
    logic [1:0] b_round_idx;

    logic [6:0] a_flags, b_flags;
    assign a_flags = {a_ready, a_clr_reg, a_put_input, a_ld_reg, a_feedback, a_round_done, a_done};
    assign b_flags = {b_ready, b_clr_reg, b_put_input, b_ld_reg, b_feedback, b_round_done, b_done};

    keccak_round_ctrl u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (a_start),
        .mode       (a_mode),
        .round_in   (a_round_in),
        .ready      (a_ready),
        .clr_reg    (a_clr_reg),
        .put_input  (a_put_input),
        .ld_reg     (a_ld_reg),
        .feedback   (a_feedback),
        .slice_idx  (a_slice_idx),
        .round_idx  (a_round_idx),
        .round_done (a_round_done),
        .done       (a_done)
    );

    keccak_round_ctrl #(
        .SLICES (4),
        .ROUNDS (3)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (b_start),
        .mode       (b_mode),
        .round_in   (b_round_in),
        .ready      (b_ready),
        .clr_reg    (b_clr_reg),
        .put_input  (b_put_input),
        .ld_reg     (b_ld_reg),
        .feedback   (b_feedback),
        .slice_idx  (b_slice_idx),
        .round_idx  (b_round_idx),
        .round_done (b_round_done),
        .done       (b_done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Flags {ready,clr,put,ld,fb,round_done,done} for a default single round, cycle c=1..68.
    function automatic int exp_a_flags(input int c);
        logic [6:0] f;
        f = {c == 68, c == 1, c == 2, (c >= 3 && c <= 66), 1'b0, c == 66, c == 67};
        return int'(f);
    endfunction

    // Full run on the 4x3 instance: CALC of round r spans cycles 3+5r..6+5r.
    task automatic check_b(input int c);
        int r, off;
        logic calc, nxt;
        logic [6:0] f;
        r    = (c - 3) / 5;
        off  = (c - 3) % 5;
        calc = (c >= 3 && c <= 16 && off <= 3);
        nxt  = (c >= 3 && c <= 16 && off == 4);
        f = {c == 18, c == 1, c == 2, calc, calc && (r > 0), calc && (off == 3), c == 17};
        check($sformatf("b_flags c%0d", c), int'(b_flags), int'(f));
        check($sformatf("b_slice c%0d", c), int'(b_slice_idx), calc ? off : 0);
        if (calc)
            check($sformatf("b_round c%0d", c), int'(b_round_idx), r);
        else if (!nxt)
            check($sformatf("b_round c%0d", c), int'(b_round_idx), (c >= 17) ? 2 : 0);
    endtask

    task automatic run_single_a(input logic [4:0] rin, input int exp_round, input int poke);
        a_start = 1'b1; a_mode = 1'b0; a_round_in = rin;
        for (int c = 1; c <= 68; c++) begin
            @(negedge clk);
            check($sformatf("a_flags c%0d", c), int'(a_flags), exp_a_flags(c));
            check($sformatf("a_slice c%0d", c), int'(a_slice_idx), (c >= 3 && c <= 66) ? c - 3 : 0);
            check($sformatf("a_round c%0d", c), int'(a_round_idx), exp_round);
            if (c == 1) a_start = 1'b0;
            if (c == poke) begin a_start = 1'b1; a_mode = 1'b1; a_round_in = '0; end
            if (c == poke + 1) begin a_start = 1'b0; a_mode = 1'b0; end
        end
    endtask

    initial begin
        int ndone, nrd, done_cyc;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst a_flags", int'(a_flags), 7'b1000000);
        check("rst a_slice", int'(a_slice_idx), 0);
        check("rst a_round", int'(a_round_idx), 0);
        check("rst b_flags", int'(b_flags), 7'b1000000);
        check("rst b_slice", int'(b_slice_idx), 0);
        check("rst b_round", int'(b_round_idx), 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle a_flags", int'(a_flags), 7'b1000000);
            check("idle b_flags", int'(b_flags), 7'b1000000);
        end

        // Single round at 5, then clamped 30->23 with a start pulse mid-CALC
        run_single_a(5'd5, 5, 0);
        run_single_a(5'd30, 23, 20);

        // Full run on 4x3
        b_start = 1'b1; b_mode = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            check_b(c);
            if (c == 1) b_start = 1'b0;
        end

        // Reset at slice 10 of round 2 of a default full run
        a_start = 1'b1; a_mode = 1'b1;
        for (int c = 1; c <= 143; c++) begin
            @(negedge clk);
            if (c == 1) a_start = 1'b0;
        end
        check("mid a_slice", int'(a_slice_idx), 10);
        check("mid a_round", int'(a_round_idx), 2);
        check("mid a_flags", int'(a_flags), 7'b0001100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort a_flags", int'(a_flags), 7'b1000000);
        check("abort a_slice", int'(a_slice_idx), 0);
        check("abort a_round", int'(a_round_idx), 0);
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_done || a_round_done) ndone++;
        end
        check("abort no pulses", ndone, 0);
        check("abort idle", int'(a_ready), 1);

        // Fresh full default run
        a_start = 1'b1; a_mode = 1'b1;
        nrd = 0; done_cyc = -1;
        for (int c = 1; c <= 1600; c++) begin
            @(negedge clk);
            if (c == 1) a_start = 1'b0;
            if (a_round_done) nrd++;
            if (a_done) begin
                done_cyc = c;
                check("full a_round@done", int'(a_round_idx), 23);
                break;
            end
        end
        check("full a_done cycle", done_cyc, 1562);
        check("full a_round_done count", nrd, 24);
        @(negedge clk);
        check("full a_ready", int'(a_flags), 7'b1000000);

        // Back-to-back on 4x3 with start held high
        b_start = 1'b1; b_mode = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            check_b(((c - 1) % 18) + 1);
            if (b_done) ndone++;
            if (c == 36) b_start = 1'b0;
        end
        @(negedge clk);
        check("b2b idle", int'(b_flags), 7'b1000000);
        check("b2b done count", ndone, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keccak_round_ctrl.md
# keccak_round_ctrl

Parametrised Moore controller for slice-serial Keccak step datapaths (iota/theta/rho units). It sequences one round or a complete multi-round permutation over `SLICES` slices per round. Internal slice and round counters drive the datapath directly, and `round_idx` feeds the round-constant ROM. It replaces the single-round, external-counter controllers in the permutation pipeline.

## Interface
Parameters:
- `SLICES`, default 64: slices processed per round; must be ≥2.
- `ROUNDS`, default 24: rounds in full mode; must be ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `mode`  in  1  sampled with `start`: 0 = single round at `round_in`, 1 = full run from round 0.
- `round_in`  in  RW  round to execute in single mode. RW = max(1, clog2(ROUNDS)).
- `ready`  out  1  high in IDLE.
- `clr_reg`  out  1  clear datapath state register.
- `put_input`  out  1  select external input into the datapath.
- `ld_reg`  out  1  load datapath register (one slice per cycle).
- `feedback`  out  1  high in CALC for every round after the first of a run; selects the register over the input.
- `slice_idx`  out  SW  current slice. SW = max(1, clog2(SLICES)).
- `round_idx`  out  RW  current round number.
- `round_done`  out  1  one-cycle pulse on the last slice of each round.
- `done`  out  1  one-cycle pulse when the run completes.

## Operation
- States: IDLE, INIT, START, CALC, NEXT, DONE. All outputs are decoded from state and counters only.
- IDLE
  - Outputs: `ready`=1.
  - If `start`=1, go to INIT and latch `mode`.
  - Load `round_idx`: mode 0 loads `round_in`, clamped to ROUNDS-1 if larger; mode 1 loads 0.
- INIT
  - Outputs: `clr_reg`=1; `slice_idx` is cleared to 0.
  - Next state: START.
- START
  - Outputs: `put_input`=1.
  - Next state: CALC.
- CALC
  - Outputs: `ld_reg`=1; `feedback`=1 if the current round is not the first of the run.
  - `slice_idx` increments each cycle from 0 to SLICES-1.
  - When `slice_idx`=SLICES-1:
    - `round_done`=1 and `slice_idx` wraps to 0.
    - If mode 0 or `round_idx`=ROUNDS-1, go to DONE; otherwise go to NEXT.
- NEXT
  - Outputs: none asserted.
  - `round_idx` increments; `slice_idx` holds 0.
  - Next state: CALC.
- DONE
  - Outputs: `done`=1; `round_idx` holds.
  - Next state: IDLE.
- `start` outside IDLE is ignored; no queuing.
- Back-to-back runs: `start` held high in IDLE on the cycle after DONE launches the next run immediately.
- Unused state encodings go to IDLE on the next edge.

## Timing
- Reset (`rst`=1 at an edge, any state, including mid-run):
  - Next cycle: state IDLE, `slice_idx`=0, `round_idx`=0, `ready`=1.
  - All other outputs 0.
  - No `done` or `round_done` pulse is produced for an aborted run.
- Cycle numbering: `start` accepted at edge 0.
- Single round:
  - INIT cycle 1, START cycle 2, CALC cycles 3..SLICES+2.
  - DONE at cycle SLICES+3; `ready` returns at cycle SLICES+4.
  - With defaults: DONE at 67.
- Full run:
  - DONE at cycle 3 + ROUNDS·SLICES + (ROUNDS-1).
  - With defaults: DONE at 1562.
  - Each round after the first takes SLICES+1 cycles (NEXT + CALC).
- `round_idx` is stable for the entire CALC of its round, so the ROM lookup is combinational.
- ROUNDS=1: full mode behaves as single mode with round 0.

## Structure
- Shared package `keccak_pkg` holds:
  - state encoding enum (3 bits);
  - width helper function `cw(n)` = max(1, clog2(n));
  - default constants `KECCAK_SLICES`=64 and `KECCAK_ROUNDS`=24.
- Sub-module `mod_counter`, parametrised modulus, with sync clear, enable, load, and a terminal-count output.
  - Two instances: slice counter and round counter.
- The FSM lives in this block.

## Test plan
- Reset / idle: assert `rst` 3 cycles → `ready`=1, all other outputs 0, indices 0. Hold `start`=0 for 10 cycles → no state change.
- Single round, defaults: `start`=1, `mode`=0, `round_in`=5.
  - `clr_reg` at cycle 1, `put_input` at 2.
  - `ld_reg` cycles 3–66 with `slice_idx` 0..63 and `round_idx`=5.
  - `round_done` and `done` at 66 and 67 respectively; `ready` at 68.
- Full run, SLICES=4, ROUNDS=3:
  - `round_done` at cycles 6, 11, 16; `done` at 17.
  - `feedback` high only in rounds 1 and 2.
  - `round_idx` 0→1→2 at the NEXT cycles.
- Clamp and ignore: `round_in`=30 in single mode → `round_idx`=23. Pulse `start` during CALC → no effect on counters or timing.
- Reset mid-run: assert `rst` at slice 10 of round 2 → IDLE next cycle, no `done`. A fresh `start` then completes normally.
- Back-to-back: `start` held high continuously → new INIT on the cycle after each IDLE. Exactly one `done` per run.
